// File: rtl/connect4_pkg.sv
// Shared definitions for the 4x4 Connect4 datapath: board geometry, detector
// verdict encoding, move-engine FSM states and the cell-index helper.
package connect4_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        FALL,
        PLACE,
        SETTLE,
        OVER
    } state_e;

    // row*4 + col; row 0 is the bottom row
    function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge pulse generator for a synchronous button level.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_d, din_q;

    assign din_d = din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= 1'b0;
        else        din_q <= din_d;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/drop_controller.sv
// Connect4 move engine: accepts a column drop, animates the falling token,
// commits it to the board and hands over the turn based on the detector verdict.
module drop_controller
    import connect4_pkg::*;
#(
    parameter int FALL_TICKS    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drop,
    input  logic [1:0]       col_sel,
    input  logic [1:0]       game_status,
    output logic [CELLS-1:0] game_board,
    output logic [CELLS-1:0] player_cells,
    output logic             current_player,
    output logic [CELLS-1:0] falling_cell,
    output logic             busy,
    output logic             move_err
);

    localparam int MAXC = (FALL_TICKS > SETTLE_CYCLES) ? FALL_TICKS : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_e           state_d, state_q;
    logic [1:0]       col_d, col_q;
    logic [1:0]       row_d, row_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [CELLS-1:0] board_d, board_q;
    logic [CELLS-1:0] cells_d, cells_q;
    logic             player_d, player_q;
    logic             err_d, err_q;
    logic             rise;
    logic [3:0]       cur_idx, below_idx;

    edge_detect u_drop_edge (
        .clk   (clk),
        .rst_n (reset),
        .din   (drop),
        .rise  (rise)
    );

    assign cur_idx   = idx(row_q, col_q);
    // wraps when row_q == 0, but that case is short-circuited below
    assign below_idx = idx(row_q - 2'd1, col_q);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        board_d  = board_q;
        cells_d  = cells_q;
        player_d = player_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (board_q[idx(2'd3, col_sel)]) begin
                        err_d = 1'b1;
                    end else begin
                        col_d   = col_sel;
                        row_d   = 2'd3;
                        cnt_d   = '0;
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                if (cnt_q == CW'(FALL_TICKS - 1)) begin
                    cnt_d = '0;
                    if (row_q == 2'd0 || board_q[below_idx]) state_d = PLACE;
                    else                                     row_d   = row_q - 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PLACE: begin
                board_d[cur_idx] = 1'b1;
                cells_d[cur_idx] = player_q;
                cnt_d            = '0;
                state_d          = SETTLE;
            end
            SETTLE: begin
                // detector output is registered, so sample only after it has seen the commit
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    if (game_status == STILL_PLAYING) begin
                        player_d = ~player_q;
                        state_d  = IDLE;
                    end else begin
                        state_d  = OVER;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            board_q  <= '0;
            cells_q  <= '0;
            player_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            board_q  <= board_d;
            cells_q  <= cells_d;
            player_q <= player_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        falling_cell = '0;
        if (state_q == FALL || state_q == PLACE) falling_cell = CELLS'(1) << cur_idx;
    end

    assign game_board     = board_q;
    assign player_cells   = cells_q;
    assign current_player = player_q;
    assign busy           = (state_q != IDLE);
    assign move_err       = err_q;

endmodule

// File: tb/tb_drop_controller.sv
// Randomized scoreboard bench for drop_controller: a column-height model
// predicts every commit / column-full error, a negedge monitor checks them.
module tb_drop_controller;

    localparam int FT = 1;
    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        drop = 1'b0;
    logic [1:0]  col_sel = 2'd0;
    logic [1:0]  game_status;
    logic [15:0] game_board, player_cells, falling_cell;
    logic        current_player, busy, move_err;

    always #5 clk = ~clk;

    drop_controller #(.FALL_TICKS(FT), .SETTLE_CYCLES(ST)) dut (
        .clk            (clk),
        .reset          (reset),
        .drop           (drop),
        .col_sel        (col_sel),
        .game_status    (game_status),
        .game_board     (game_board),
        .player_cells   (player_cells),
        .current_player (current_player),
        .falling_cell   (falling_cell),
        .busy           (busy),
        .move_err       (move_err)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] board;
        logic [15:0] cells;
        bit          player;
        int          e0;
        int          lat;
        int          col;
        int          k;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // reference model: column heights, board images, player to move
    int        height[4];
    bit [15:0] mboard, mcells;
    bit        mplayer;
    int        mcount;
    bit        force_win;

    assign game_status = force_win ? 2'b01 : ((mcount == 16) ? 2'b11 : 2'b00);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit [15:0]   prev_board = '0;
    bit          prev_busy = 1'b0, prev_err = 1'b0, pend = 1'b0, pend_player = 1'b0;
    logic [15:0] trace[$];

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_board = '0;
            prev_busy  = 1'b0;
            prev_err   = 1'b0;
            pend       = 1'b0;
            trace.delete();
        end else begin
            chk("cells_within_board", player_cells & ~game_board, 32'd0);
            if (falling_cell != 16'd0 && (trace.size() == 0 || trace[$] != falling_cell))
                trace.push_back(falling_cell);
            if (prev_err) chk("err_single_pulse", move_err, 32'd0);
            if (move_err) begin
                if (q.size() == 0) chk("unexpected_move_err", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("err_expected", e.is_err, 32'd1);
                    chk("err_board", game_board, e.board);
                    chk("err_player", current_player, e.player);
                    chk("err_busy", busy, 32'd0);
                end
            end
            if (game_board !== prev_board) begin
                if (q.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("commit_expected", e.is_err, 32'd0);
                    chk("commit_board", game_board, e.board);
                    chk("commit_cells", player_cells, e.cells);
                    chk("commit_latency", cyc - e.e0, e.lat);
                    chk("fall_steps", trace.size(), 4 - e.k);
                    if (trace.size() > 0) begin
                        chk("fall_first", trace[0], 32'd1 << (12 + e.col));
                        chk("fall_last", trace[$], 32'd1 << (e.k * 4 + e.col));
                    end
                    pend        = 1'b1;
                    pend_player = e.player;
                end
                trace.delete();
            end
            if (prev_busy && !busy) begin
                chk("idle_after_commit", pend, 32'd1);
                chk("turn_handover", current_player, pend_player);
                pend = 1'b0;
            end
            prev_board = game_board;
            prev_busy  = busy;
            prev_err   = move_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic model_clear();
        for (int i = 0; i < 4; i++) height[i] = 0;
        mboard    = '0;
        mcells    = '0;
        mplayer   = 1'b0;
        mcount    = 0;
        force_win = 1'b0;
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_board"}, game_board, 32'd0);
        chk({tag, "_cells"}, player_cells, 32'd0);
        chk({tag, "_player"}, current_player, 32'd0);
        chk({tag, "_falling"}, falling_cell, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_err"}, move_err, 32'd0);
    endtask

    task automatic do_reset();
        drop  = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset");
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue(input int c, input bit dbl);
        exp_t e;
        int   k, n;
        bit   over;
        k      = height[c];
        e.col  = c;
        e.k    = k;
        e.e0   = cyc + 1;
        e.lat  = (4 - k) * FT + 1;
        e.is_err = (k == 4);
        over   = 1'b0;
        if (k < 4) begin
            mboard[k*4 + c] = 1'b1;
            mcells[k*4 + c] = mplayer;
            height[c]++;
            mcount++;
            over = force_win || (mcount == 16);
            if (!over) mplayer = ~mplayer;
        end
        e.board  = mboard;
        e.cells  = mcells;
        e.player = mplayer;
        q.push_back(e);
        col_sel = 2'(c);
        drop    = 1'b1;
        @(negedge clk);
        if (dbl) begin
            drop = 1'b0;
            @(negedge clk);
            drop = 1'b1;
            @(negedge clk);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drop    = 1'b0;
        col_sel = 2'($urandom_range(0, 3));
        if (over) begin
            repeat ((4 - k) * FT + ST + 6) @(negedge clk);
            chk("over_busy", busy, 32'd1);
            chk("over_player", current_player, mplayer);
        end else begin
            n = 0;
            @(negedge clk);
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("move_done_in_time", busy, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic ignored_drops();
        repeat (3) begin
            col_sel = 2'($urandom_range(0, 3));
            drop    = 1'b1;
            @(negedge clk);
            drop    = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("over_board_frozen", game_board, mboard);
        chk("over_cells_frozen", player_cells, mcells);
        chk("over_stays_busy", busy, 32'd1);
        chk("over_player_frozen", current_player, mplayer);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        // first and second drop on column 2, double-rise during a fall
        issue(2, 1'b0);
        issue(2, 1'b0);
        issue(1, 1'b1);
        // fill column 0, then overfill it
        repeat (4) issue(0, 1'b0);
        issue(0, 1'b0);
        // random play until the board is full -> detector reports a tie
        n = 0;
        while (mcount < 16 && n < 300) begin
            issue($urandom_range(0, 3), 1'b0);
            n++;
        end
        ignored_drops();

        // reset in the middle of a fall aborts the move
        do_reset();
        issue(0, 1'b0);
        issue(3, 1'b0);
        col_sel = 2'd1;
        drop    = 1'b1;
        @(negedge clk);
        drop    = 1'b0;
        n = 0;
        while (falling_cell != 16'h0200 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fall_reaches_0200", falling_cell, 32'h0200);
        do_reset();
        issue(1, 1'b0);

        // detector reports a win while settling
        issue($urandom_range(0, 3), 1'b0);
        force_win = 1'b1;
        issue($urandom_range(0, 3), 1'b0);
        ignored_drops();

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/drop_controller.md
Name: drop_controller

Overview:
- Upstream move engine for the 4x4 Connect4 board. It owns the `game_board` (occupied) and `player_cells` (owner) registers that feed the winner detector.
- It accepts a column select and a drop button, then animates the token falling one row at a time with gravity.
- It commits the token to the board and waits for the detector's registered verdict. Depending on that verdict it either hands the turn to the other player or freezes the game.
- Cell index = row*4 + col. Row 0 (bits 3:0) is the bottom row; row 3 (bits 15:12) is the top row.

Parameters:
- FALL_TICKS, 1, clock cycles the token dwells at each row during the fall animation (>=1).
- SETTLE_CYCLES, 2, cycles waited after a commit before `game_status` is sampled (>=2; the detector has 1-cycle registered latency).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- drop  in  1  drop button, synchronous level; rising edge is detected internally.
- col_sel  in  2  target column 0..3.
- game_status  in  2  detector verdict: 00 playing, 01 P1 wins, 10 P2 wins, 11 tie.
- game_board  out  16  1 = cell occupied.
- player_cells  out  16  owner of occupied cell: 0 = P1, 1 = P2; 0 for empty cells.
- current_player  out  1  player to move: 0 = P1, 1 = P2.
- falling_cell  out  16  one-hot animated token position; all-zero when no token is falling.
- busy  out  1  high in every state except IDLE.
- move_err  out  1  one-cycle pulse when a drop targets a full column.

Behaviour:
- Reset (reset = 0, async): state IDLE, all board registers 0, `current_player` 0, `falling_cell` 0, `move_err` 0, `drop_q` 0. Reset mid-fall or mid-settle aborts the move; no partial commit.
- Edge detect: `rise = drop & ~drop_q`, where `drop_q` is registered every cycle. A rise is acted on only in IDLE. Rises in any other state are discarded, not queued.
- IDLE, on rise:
  - If `game_board[12+col_sel] == 1` (column full): pulse `move_err` on the next cycle, stay IDLE.
  - Otherwise: latch `col = col_sel`, set `row_ptr = 3`, clear the tick counter, go to FALL.
- FALL:
  - `falling_cell = 1 << (row_ptr*4 + col)`.
  - At the end of each FALL_TICKS dwell: if `row_ptr == 0` or cell `(row_ptr-1)*4+col` is occupied, go to PLACE; else decrement `row_ptr`.
- PLACE (1 cycle):
  - At the clock edge, set `game_board[row_ptr*4+col] = 1` and `player_cells[row_ptr*4+col] = current_player`.
  - `falling_cell` goes to 0; go to SETTLE with counter cleared.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then sample `game_status`.
  - If 00: toggle `current_player`, go to IDLE.
  - Otherwise: go to OVER, leaving `current_player` unchanged.
- OVER: terminal state; drops are ignored and `busy` = 1. Exit is by reset only.
- Latency: rise sampled at edge E0 (state becomes FALL after E0). For a column holding k tokens, the board bit is visible after edge E0 + (4-k)*FALL_TICKS + 1. IDLE is re-entered SETTLE_CYCLES edges later.
- Invariants:
  - `player_cells & ~game_board == 0` always.
  - Board bits never clear except on reset.
  - Each column fills contiguously from row 0.
- `col_sel` is sampled only on the accepting rise; changes during FALL have no effect.
- A full board with no winner is reported by the detector as 11 and leads to OVER.

Decomposition:
- Shared package `connect4_pkg` holds:
  - status encodings (STILL_PLAYING, P1_WINS, P2_WINS, TIE);
  - ROWS/COLS = 4;
  - FSM state encoding (IDLE, FALL, PLACE, SETTLE, OVER);
  - a cell-index function `idx(row, col)`.
- One natural sub-module: `edge_detect`, a registered rising-edge pulse generator for `drop`, reusable for other buttons.

Test Plan:
- After reset, drop on col 2 with FALL_TICKS = 1: `falling_cell` steps 0x4000 → 0x0400 → 0x0040 → 0x0004; then `game_board` = 0x0004, `player_cells` = 0x0000, `current_player` = 1, `busy` = 0.
- Second drop on col 2 (P2): token stops at row 1; `game_board` = 0x0044, `player_cells` = 0x0040, landing 1 FALL_TICKS earlier than the first drop.
- Fill col 0 with 4 drops, then a fifth drop on col 0: single-cycle `move_err` pulse; board unchanged, `current_player` unchanged, `busy` stays 0.
- Drive `game_status` = 01 during SETTLE after a commit: state OVER; `busy` = 1; later drops leave the board unchanged; `current_player` not toggled.
- Assert reset while `falling_cell` = 0x0200: all outputs go to 0 asynchronously; no board bit is set. After release, a drop plays normally as P1.
- Toggle `drop` twice during FALL: second rise ignored; exactly one token is committed and only one turn change occurs.
